// File: rtl/smi_frame_arbiter_wrr_x2.sv
// Two-input SMI frame arbiter with weighted round-robin grants counted in frames.
// Each input has one register stage; the output is a 2-entry buffer; frames are never interleaved.
module smi_frame_arbiter_wrr_x2 #(
    parameter int FlitWidth = 2
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   smiInAReady,
    input  logic [7:0]             smiInAEofc,
    input  logic [FlitWidth*8-1:0] smiInAData,
    output logic                   smiInAStop,
    input  logic                   smiInBReady,
    input  logic [7:0]             smiInBEofc,
    input  logic [FlitWidth*8-1:0] smiInBData,
    output logic                   smiInBStop,
    output logic                   smiOutReady,
    output logic [7:0]             smiOutEofc,
    output logic [FlitWidth*8-1:0] smiOutData,
    input  logic                   smiOutStop,
    input  logic [3:0]             cfgWeightA,
    input  logic [3:0]             cfgWeightB,
    output logic                   grantA,
    output logic                   grantB,
    output logic [15:0]            statFramesA,
    output logic [15:0]            statFramesB
);

    localparam int DataWidth = FlitWidth * 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER_A = 2'd1,
        XFER_B = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [3:0]     credit_reg, credit_next;
    logic           last_b_reg, last_b_next;
    logic [15:0]    stat_a_reg, stat_a_next;
    logic [15:0]    stat_b_reg, stat_b_next;

    // Index 0 is port A, index 1 is port B throughout.
    logic [1:0]           in_ready;
    logic [1:0]           in_stop;
    logic [1:0]           stage_valid;
    logic [1:0]           fwd;
    logic [1:0]           grant;
    logic [1:0]           frame_end;
    logic [7:0]           in_eofc [2];
    logic [DataWidth-1:0] in_data [2];
    logic [7:0]           stage_eofc [2];
    logic [DataWidth-1:0] stage_data [2];
    logic [3:0]           weight [2];
    logic                 space;
    logic                 cur;

    assign in_ready   = {smiInBReady, smiInAReady};
    assign in_eofc[0] = smiInAEofc;
    assign in_eofc[1] = smiInBEofc;
    assign in_data[0] = smiInAData;
    assign in_data[1] = smiInBData;
    assign smiInAStop = in_stop[0];
    assign smiInBStop = in_stop[1];

    assign weight[0] = (cfgWeightA == 4'd0) ? 4'd1 : cfgWeightA;
    assign weight[1] = (cfgWeightB == 4'd0) ? 4'd1 : cfgWeightB;

    assign grant  = {state_reg == XFER_B, state_reg == XFER_A};
    assign grantA = grant[0] & ~srst;
    assign grantB = grant[1] & ~srst;
    assign cur    = (state_reg == XFER_B);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stage
            logic                 valid_reg;
            logic [7:0]           eofc_reg;
            logic [DataWidth-1:0] data_reg;
            logic                 take;

            assign fwd[gi]        = grant[gi] & valid_reg & space;
            assign in_stop[gi]    = ~srst & valid_reg & ~fwd[gi];
            assign take           = fwd[gi] | ~valid_reg;
            assign frame_end[gi]  = fwd[gi] & (eofc_reg != 8'd0);
            assign stage_valid[gi] = valid_reg;
            assign stage_eofc[gi] = eofc_reg;
            assign stage_data[gi] = data_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    valid_reg <= 1'b0;
                end else if (take) begin
                    valid_reg <= in_ready[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (take && in_ready[gi]) begin
                    eofc_reg <= in_eofc[gi];
                    data_reg <= in_data[gi];
                end
            end
        end
    endgenerate

    // Output buffer: two entries so a stall on smiOut never needs a combinational
    // path back to the input Stop signals.
    logic [7:0]           out_eofc_mem [2];
    logic [DataWidth-1:0] out_data_mem [2];
    logic                 wr_ptr_reg;
    logic                 rd_ptr_reg;
    logic [1:0]           count_reg;
    logic                 push;
    logic                 pop;
    logic [7:0]           push_eofc;
    logic [DataWidth-1:0] push_data;

    assign space       = (count_reg != 2'd2);
    assign push        = |fwd;
    assign push_eofc   = fwd[1] ? stage_eofc[1] : stage_eofc[0];
    assign push_data   = fwd[1] ? stage_data[1] : stage_data[0];
    assign smiOutReady = ~srst & (count_reg != 2'd0);
    assign pop         = smiOutReady & ~smiOutStop;
    assign smiOutEofc  = out_eofc_mem[rd_ptr_reg];
    assign smiOutData  = out_data_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            out_eofc_mem[wr_ptr_reg] <= push_eofc;
            out_data_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg  <= IDLE;
            credit_reg <= 4'd0;
            last_b_reg <= 1'b1;
            stat_a_reg <= 16'd0;
            stat_b_reg <= 16'd0;
        end else begin
            state_reg  <= state_next;
            credit_reg <= credit_next;
            last_b_reg <= last_b_next;
            stat_a_reg <= stat_a_next;
            stat_b_reg <= stat_b_next;
        end
    end

    // At a frame end the granted stage reloads from its input in the same cycle,
    // so "port still has data" is judged on the input Ready to avoid a bubble.
    always_comb begin
        state_next  = state_reg;
        credit_next = credit_reg;
        last_b_next = last_b_reg;
        stat_a_next = stat_a_reg;
        stat_b_next = stat_b_reg;
        case (state_reg)
            IDLE: begin
                if (space) begin
                    if (stage_valid[0] && (!stage_valid[1] || last_b_reg)) begin
                        state_next  = XFER_A;
                        credit_next = weight[0];
                        last_b_next = 1'b0;
                    end else if (stage_valid[1]) begin
                        state_next  = XFER_B;
                        credit_next = weight[1];
                        last_b_next = 1'b1;
                    end
                end
            end
            XFER_A, XFER_B: begin
                if (frame_end[cur]) begin
                    if (cur) begin
                        stat_b_next = stat_b_reg + 16'd1;
                    end else begin
                        stat_a_next = stat_a_reg + 16'd1;
                    end
                    if (credit_reg > 4'd1 && in_ready[cur]) begin
                        credit_next = credit_reg - 4'd1;
                    end else if (stage_valid[~cur] || in_ready[~cur]) begin
                        state_next  = cur ? XFER_A : XFER_B;
                        credit_next = weight[~cur];
                        last_b_next = ~cur;
                    end else if (in_ready[cur]) begin
                        credit_next = weight[cur];
                    end else begin
                        state_next  = IDLE;
                        credit_next = credit_reg - 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign statFramesA = stat_a_reg;
    assign statFramesB = stat_b_reg;

endmodule
